// File: rtl/xc_sha2_msched.sv
`default_nettype none
// ============================================================================
//  Module   : xc_sha2_msched
//  Purpose  : SHA-2 message-schedule engine. Loads one 16-word block, then
//             streams W[0..ROUNDS-1] through a self-running 16-word window.
//             XLEN=32 -> SHA-256 (64 rounds), XLEN=64 -> SHA-512 (80 rounds).
//  Revision : 1.0  initial release
// ============================================================================
module xc_sha2_msched #(
    parameter int XLEN = 64
) (
    input  logic            g_clk,
    input  logic            g_resetn,
    input  logic            clear,
    input  logic            ld_valid,
    output logic            ld_ready,
    input  logic [XLEN-1:0] ld_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_data,
    output logic [6:0]      out_idx,
    output logic            out_last
);

    localparam int         ROUNDS   = (XLEN == 32) ? 64 : 80;
    localparam logic [6:0] LAST_IDX = 7'(ROUNDS - 1);

    localparam logic [0:0] ST_LOAD = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Only the two SHA-2 word widths have defined sigma functions.
    generate
        if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
            $error("xc_sha2_msched: XLEN must be 32 or 64");
        end
    endgenerate

    function automatic logic [XLEN-1:0] ror(input logic [XLEN-1:0] x, input int n);
        return (x >> n) | (x << (XLEN - n));
    endfunction

    function automatic logic [XLEN-1:0] sigma0(input logic [XLEN-1:0] x);
        if (XLEN == 32) return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
        else            return ror(x, 1) ^ ror(x, 8)  ^ (x >> 7);
    endfunction

    function automatic logic [XLEN-1:0] sigma1(input logic [XLEN-1:0] x);
        if (XLEN == 32) return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
        else            return ror(x, 19) ^ ror(x, 61) ^ (x >> 6);
    endfunction

    logic [0:0]      state_q, state_d;
    logic [3:0]      lcnt_q,  lcnt_d;
    logic [6:0]      t_q,     t_d;
    logic [XLEN-1:0] win_q [16];
    logic [XLEN-1:0] win_d [16];

    logic            w_ld_hs;
    logic            w_out_hs;
    logic [XLEN-1:0] w_next;

    // Window slot k holds W[t+k], so W[t+16] uses slots 14, 9, 1 and 0.
    assign w_next   = sigma1(win_q[14]) + win_q[9] + sigma0(win_q[1]) + win_q[0];
    assign w_ld_hs  = ld_valid  && (state_q == ST_LOAD);
    assign w_out_hs = out_ready && (state_q == ST_RUN);

    assign ld_ready  = (state_q == ST_LOAD);
    assign out_valid = (state_q == ST_RUN);
    assign out_data  = out_valid ? win_q[0] : '0;
    assign out_idx   = t_q;
    assign out_last  = out_valid && (t_q == LAST_IDX);

    // Next-state: clear wins over any handshake; load fills, run shifts.
    always_comb begin
        state_d = state_q;
        lcnt_d  = lcnt_q;
        t_d     = t_q;
        win_d   = win_q;
        if (clear) begin
            state_d = ST_LOAD;
            lcnt_d  = 4'd0;
            t_d     = 7'd0;
        end else if (w_ld_hs) begin
            win_d[lcnt_q] = ld_data;
            if (lcnt_q == 4'd15) begin
                state_d = ST_RUN;
                lcnt_d  = 4'd0;
                t_d     = 7'd0;
            end else begin
                lcnt_d = lcnt_q + 4'd1;
            end
        end else if (w_out_hs) begin
            for (int i = 0; i < 15; i++) begin
                win_d[i] = win_q[i + 1];
            end
            win_d[15] = w_next;
            if (t_q == LAST_IDX) begin
                state_d = ST_LOAD;
                t_d     = 7'd0;
            end else begin
                t_d = t_q + 7'd1;
            end
        end
    end

    // State registers; reset additionally zeroes the window.
    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            state_q <= ST_LOAD;
            lcnt_q  <= 4'd0;
            t_q     <= 7'd0;
            for (int i = 0; i < 16; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            lcnt_q  <= lcnt_d;
            t_q     <= t_d;
            win_q   <= win_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_xc_sha2_msched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_xc_sha2_msched
//  Purpose  : Self-checking bench for xc_sha2_msched, one SHA-256 instance
//             (index 0) and one SHA-512 instance (index 1), compared every
//             cycle against a recurrence-based schedule model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_xc_sha2_msched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       rstn, clr, ldv, ordy;
    logic [1:0][63:0] ldd;

    logic             ldr0, ov0, ol0, ldr1, ov1, ol1;
    logic [31:0]      od0;
    logic [63:0]      od1;
    logic [6:0]       oi0, oi1;

    logic [1:0]       ldr, ov, ol;
    logic [1:0][63:0] od;
    logic [1:0][6:0]  oi;

    assign ldr = {ldr1, ldr0};
    assign ov  = {ov1, ov0};
    assign ol  = {ol1, ol0};
    assign od  = {od1, {32'h0, od0}};
    assign oi  = {oi1, oi0};

    xc_sha2_msched #(.XLEN(32)) u_dut32 (
        .g_clk(clk), .g_resetn(rstn[0]), .clear(clr[0]),
        .ld_valid(ldv[0]), .ld_ready(ldr0), .ld_data(ldd[0][31:0]),
        .out_valid(ov0), .out_ready(ordy[0]), .out_data(od0),
        .out_idx(oi0), .out_last(ol0)
    );

    xc_sha2_msched #(.XLEN(64)) u_dut64 (
        .g_clk(clk), .g_resetn(rstn[1]), .clear(clr[1]),
        .ld_valid(ldv[1]), .ld_ready(ldr1), .ld_data(ldd[1]),
        .out_valid(ov1), .out_ready(ordy[1]), .out_data(od1),
        .out_idx(oi1), .out_last(ol1)
    );

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    logic [63:0] sched [2][80];
    logic [63:0] blk   [16];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- reference model: plain SHA-2 recurrence ----------------
    function automatic logic [63:0] msk(input int xl);
        return (xl == 32) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
    endfunction

    function automatic logic [63:0] ror(input logic [63:0] v, input int n, input int xl);
        return ((v >> n) | (v << (xl - n))) & msk(xl);
    endfunction

    function automatic logic [63:0] s0(input logic [63:0] v, input int xl);
        if (xl == 32) return ror(v, 7, xl) ^ ror(v, 18, xl) ^ (v >> 3);
        return ror(v, 1, xl) ^ ror(v, 8, xl) ^ (v >> 7);
    endfunction

    function automatic logic [63:0] s1(input logic [63:0] v, input int xl);
        if (xl == 32) return ror(v, 17, xl) ^ ror(v, 19, xl) ^ (v >> 10);
        return ror(v, 19, xl) ^ ror(v, 61, xl) ^ (v >> 6);
    endfunction

    function automatic int rounds(input int d);
        return (d == 0) ? 64 : 80;
    endfunction

    task automatic build(input int d);
        int xl = (d == 0) ? 32 : 64;
        for (int t = 0; t < 80; t++) begin
            if (t < 16) sched[d][t] = blk[t] & msk(xl);
            else sched[d][t] = (s1(sched[d][t-2], xl) + sched[d][t-7]
                               + s0(sched[d][t-15], xl) + sched[d][t-16]) & msk(xl);
        end
    endtask

    task automatic rand_blk();
        for (int i = 0; i < 16; i++) blk[i] = {$urandom, $urandom};
    endtask

    // ---------------- per-cycle compare process ----------------
    int          k  [2];
    int          lc [2];
    bit          idle_nx [2];
    bit          run_nx  [2];
    bit          stall   [2];
    logic [63:0] pd [2];
    logic [6:0]  pi [2];

    initial begin
        for (int d = 0; d < 2; d++) begin
            k[d] = 0; lc[d] = 0; idle_nx[d] = 0; run_nx[d] = 0; stall[d] = 0;
            pd[d] = '0; pi[d] = '0;
        end
        forever begin
            @(negedge clk);
            if (mon_en) begin
                for (int d = 0; d < 2; d++) begin
                    string tg = (d == 0) ? "x32" : "x64";
                    if (idle_nx[d]) begin
                        check({tg, " idle out_valid"}, 64'(ov[d]), 64'd0);
                        check({tg, " idle ld_ready"}, 64'(ldr[d]), 64'd1);
                    end
                    if (run_nx[d]) check({tg, " run out_valid"}, 64'(ov[d]), 64'd1);
                    if (stall[d]) begin
                        check({tg, " stall valid"}, 64'(ov[d]), 64'd1);
                        check({tg, " stall data"}, od[d], pd[d]);
                        check({tg, " stall idx"}, 64'(oi[d]), 64'(pi[d]));
                    end
                    check({tg, " ld_ready vs out_valid"}, 64'(ldr[d]), 64'(!ov[d]));
                    if (ov[d] === 1'b1) begin
                        check($sformatf("%s data W[%0d]", tg, k[d]), od[d], sched[d][k[d]]);
                        check($sformatf("%s idx W[%0d]", tg, k[d]), 64'(oi[d]), 64'(k[d]));
                        check($sformatf("%s last W[%0d]", tg, k[d]), 64'(ol[d]),
                              64'(k[d] == rounds(d) - 1));
                    end
                    idle_nx[d] = 0;
                    run_nx[d]  = 0;
                    stall[d]   = ov[d] && !ordy[d] && rstn[d] && !clr[d];
                    pd[d]      = od[d];
                    pi[d]      = oi[d];
                    if (!rstn[d] || clr[d]) begin
                        k[d] = 0; lc[d] = 0; idle_nx[d] = 1;
                    end else begin
                        if (ldv[d] && ldr[d]) begin
                            if (lc[d] == 15) begin lc[d] = 0; run_nx[d] = 1; end
                            else lc[d]++;
                        end
                        if (ov[d] && ordy[d]) begin
                            if (k[d] == rounds(d) - 1) begin k[d] = 0; idle_nx[d] = 1; end
                            else k[d]++;
                        end
                    end
                end
            end
        end
    end

    // ---------------- drivers (entered and left at posedge+1) ----------------
    task automatic chk_reset(input int d);
        @(negedge clk);
        check("reset ld_ready", 64'(ldr[d]), 64'd1);
        check("reset out_valid", 64'(ov[d]), 64'd0);
        check("reset out_data", od[d], 64'd0);
        check("reset out_idx", 64'(oi[d]), 64'd0);
        check("reset out_last", 64'(ol[d]), 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic do_reset(input int d);
        rstn[d] = 1'b0; ldv[d] = 1'b0; ordy[d] = 1'b0; clr[d] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstn[d] = 1'b1;
        chk_reset(d);
    endtask

    task automatic load(input int d, input int nw, input bit bub);
        for (int i = 0; i < nw; i++) begin
            if (bub) begin
                while ($urandom_range(0, 2) == 0) begin
                    ldv[d] = 1'b0;
                    ldd[d] = {$urandom, $urandom};
                    @(posedge clk); #1;
                end
            end
            ldv[d] = 1'b1;
            ldd[d] = blk[i];
            @(posedge clk); #1;
        end
        ldv[d] = 1'b0;
    endtask

    // mode 0: free run, 1: stall 5 at idx 20 then random, 2: clear at idx 40,
    // 3: stop at idx 10 so the caller can reset mid-run. ld_valid is noisy.
    task automatic drain(input int d, input int mode);
        int cyc = 0;
        int stl = 0;
        bit fin = 0;
        while (1) begin
            ordy[d] = 1'b1;
            if (mode == 1) begin
                if (oi[d] == 7'd20 && stl < 5) begin ordy[d] = 1'b0; stl++; end
                else if (stl >= 5) ordy[d] = 1'($urandom_range(0, 1));
            end
            if (mode == 2 && oi[d] == 7'd40) clr[d] = 1'b1;
            if (mode == 3 && oi[d] == 7'd10) begin ordy[d] = 1'b0; break; end
            ldv[d] = 1'($urandom_range(0, 1));
            ldd[d] = {$urandom, $urandom};
            if (ov[d] && ordy[d] && ol[d]) fin = 1;
            @(posedge clk); #1;
            if (clr[d] || fin) begin
                clr[d] = 1'b0; ldv[d] = 1'b0; ordy[d] = 1'b0;
                break;
            end
            if (++cyc > 1000) begin
                checks++; errors++;
                $display("FAIL drain timeout: got no out_last after %0d cycles", cyc);
                ldv[d] = 1'b0; ordy[d] = 1'b0;
                break;
            end
        end
    endtask

    initial begin
        rstn = '0; clr = '0; ldv = '0; ordy = '0; ldd = '0;
        repeat (3) @(posedge clk);
        #1;
        mon_en = 1'b1;
        rstn   = '1;
        chk_reset(0);
        chk_reset(1);

        // SHA-256 "abc"
        for (int i = 0; i < 16; i++) blk[i] = '0;
        blk[0] = 64'h6162_6380; blk[15] = 64'h18;
        build(0);
        check("model256 W16", sched[0][16], 64'h6162_6380);
        check("model256 W17", sched[0][17], 64'h000F_0000);
        load(0, 16, 0);
        drain(0, 0);

        // SHA-512 "abc"
        blk[0] = 64'h6162_6380_0000_0000; blk[15] = 64'h18;
        build(1);
        check("model512 W16", sched[1][16], 64'h6162_6380_0000_0000);
        check("model512 W17", sched[1][17], 64'h0003_0000_0000_00C0);
        load(1, 16, 0);
        drain(1, 0);

        // Backpressure with load bubbles and RUN-time ld noise
        rand_blk(); build(1); load(1, 16, 1); drain(1, 1);

        // clear at idx 40, then a fresh block
        rand_blk(); build(1); load(1, 16, 1); drain(1, 2);
        rand_blk(); build(1); load(1, 16, 0); drain(1, 0);

        // Reset mid-load, reset mid-run, then an all-zero block
        rand_blk(); build(1); load(1, 7, 1); do_reset(1);
        rand_blk(); build(1); load(1, 16, 0); drain(1, 3); do_reset(1);
        for (int i = 0; i < 16; i++) blk[i] = '0;
        build(1); load(1, 16, 1); drain(1, 0);

        // SHA-256 random block with backpressure
        rand_blk(); build(0); load(0, 16, 1); drain(0, 1);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
